// File: rtl/alu_mc.sv
// rtl/alu_mc.sv - multi-cycle ALU: single-cycle logic/arith/shift ops, iterative MULTU/DIVU
module alu_mc #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       gin,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [SHW-1:0]   shamt,
  output logic [WIDTH-1:0] sum,
  output logic [WIDTH-1:0] hi,
  output logic             zout,
  output logic             ovf,
  output logic             busy,
  output logic             done
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] STEPS = CW'(WIDTH);

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_SRL  = 4'b0011;
  localparam logic [3:0] OP_SLL  = 4'b0100;
  localparam logic [3:0] OP_SRA  = 4'b0101;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_SLT  = 4'b0111;
  localparam logic [3:0] OP_XOR  = 4'b1000;
  localparam logic [3:0] OP_NOR  = 4'b1001;
  localparam logic [3:0] OP_SLTU = 4'b1010;
  localparam logic [3:0] OP_MULU = 4'b1100;
  localparam logic [3:0] OP_DIVU = 4'b1101;

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state, next_state;
  logic [CW-1:0]    cnt;
  logic             is_div;
  logic [WIDTH-1:0] opb, acc_hi, acc_lo;

  logic [WIDTH-1:0] add_res;
  logic [WIDTH:0]   sub_full;
  logic             add_ovf, sub_ovf, iterative;
  logic [WIDTH-1:0] alu_res;
  logic             alu_ovf;

  assign add_res  = a + b;
  assign sub_full = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};
  assign add_ovf  = (a[WIDTH-1] == b[WIDTH-1]) && (add_res[WIDTH-1] != a[WIDTH-1]);
  assign sub_ovf  = (a[WIDTH-1] != b[WIDTH-1]) && (sub_full[WIDTH-1] != a[WIDTH-1]);
  assign iterative = (gin == OP_MULU) || (gin == OP_DIVU);

  always_comb begin
    alu_res = '0;
    alu_ovf = 1'b0;
    case (gin)
      OP_AND:  alu_res = a & b;
      OP_OR:   alu_res = a | b;
      OP_ADD:  begin alu_res = add_res; alu_ovf = add_ovf; end
      OP_SRL:  alu_res = b >> shamt;
      OP_SLL:  alu_res = b << shamt;
      OP_SRA:  alu_res = $signed(b) >>> shamt;
      OP_SUB:  begin alu_res = sub_full[WIDTH-1:0]; alu_ovf = sub_ovf; end
      OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, sub_full[WIDTH-1] ^ sub_ovf};
      OP_XOR:  alu_res = a ^ b;
      OP_NOR:  alu_res = ~(a | b);
      OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, ~sub_full[WIDTH]};
      default: alu_res = '0;
    endcase
  end

  // Multiply step: conditionally add multiplicand into the high half, then shift the pair right.
  logic [WIDTH:0]   mul_add;
  logic [WIDTH-1:0] mul_hi, mul_lo;
  assign mul_add = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opb} : {(WIDTH+1){1'b0}});
  assign mul_hi  = mul_add[WIDTH:1];
  assign mul_lo  = {mul_add[0], acc_lo[WIDTH-1:1]};

  // Restoring divide step: acc_hi is the partial remainder, quotient bits shift into acc_lo.
  logic [WIDTH:0]   div_sh;
  logic             div_ge;
  logic [WIDTH-1:0] div_diff, div_hi, div_lo;
  assign div_sh   = {acc_hi, acc_lo[WIDTH-1]};
  assign div_ge   = div_sh >= {1'b0, opb};
  assign div_diff = div_sh[WIDTH-1:0] - opb;
  assign div_hi   = div_ge ? div_diff : div_sh[WIDTH-1:0];
  assign div_lo   = {acc_lo[WIDTH-2:0], div_ge};

  logic [WIDTH-1:0] step_hi, step_lo;
  assign step_hi = is_div ? div_hi : mul_hi;
  assign step_lo = is_div ? div_lo : mul_lo;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (start && iterative) next_state = RUN;
      RUN:     if (cnt == CW'(1)) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  assign busy = (state == RUN);

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt    <= '0;
      is_div <= 1'b0;
      opb    <= '0;
      acc_hi <= '0;
      acc_lo <= '0;
      sum    <= '0;
      hi     <= '0;
      zout   <= 1'b1;
      ovf    <= 1'b0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      if (state == IDLE) begin
        if (start && iterative) begin
          cnt    <= STEPS;
          is_div <= gin[0];
          opb    <= b;
          acc_hi <= '0;
          acc_lo <= a;
        end else if (start) begin
          sum  <= alu_res;
          hi   <= '0;
          zout <= (alu_res == '0);
          ovf  <= alu_ovf;
          done <= 1'b1;
        end
      end else begin
        cnt    <= cnt - CW'(1);
        acc_hi <= step_hi;
        acc_lo <= step_lo;
        if (cnt == CW'(1)) begin
          sum  <= step_lo;
          hi   <= step_hi;
          zout <= (step_lo == '0);
          ovf  <= 1'b0;
          done <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_alu_mc.sv
// tb/tb_alu_mc.sv - self-checking bench for alu_mc at WIDTH=32 and WIDTH=8
module tb_alu_mc;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        s32, z32, o32, bz32, d32;
  logic [3:0]  g32;
  logic [31:0] a32, b32, sum32, hi32;
  logic [4:0]  sh32;
  logic        s8, z8, o8, bz8, d8;
  logic [3:0]  g8;
  logic [7:0]  a8, b8, sum8, hi8;
  logic [2:0]  sh8;

  alu_mc #(.WIDTH(32)) u32 (
    .clk(clk), .reset(reset), .start(s32), .gin(g32), .a(a32), .b(b32), .shamt(sh32),
    .sum(sum32), .hi(hi32), .zout(z32), .ovf(o32), .busy(bz32), .done(d32)
  );

  alu_mc #(.WIDTH(8)) u8 (
    .clk(clk), .reset(reset), .start(s8), .gin(g8), .a(a8), .b(b8), .shamt(sh8),
    .sum(sum8), .hi(hi8), .zout(z8), .ovf(o8), .busy(bz8), .done(d8)
  );

  int total = 0;
  int passed = 0;

  task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(int w, bit st, logic [3:0] g, longint unsigned av, longint unsigned bv,
                       longint unsigned sh);
    if (w == 32) begin
      s32 = st; g32 = g; a32 = av[31:0]; b32 = bv[31:0]; sh32 = sh[4:0];
    end else begin
      s8 = st; g8 = g; a8 = av[7:0]; b8 = bv[7:0]; sh8 = sh[2:0];
    end
  endtask

  function automatic logic [63:0] osum(int w);
    return (w == 32) ? {32'b0, sum32} : {56'b0, sum8};
  endfunction
  function automatic logic [63:0] ohi(int w);
    return (w == 32) ? {32'b0, hi32} : {56'b0, hi8};
  endfunction
  function automatic logic ozout(int w); return (w == 32) ? z32 : z8; endfunction
  function automatic logic oovf(int w);  return (w == 32) ? o32 : o8; endfunction
  function automatic logic obusy(int w); return (w == 32) ? bz32 : bz8; endfunction
  function automatic logic odone(int w); return (w == 32) ? d32 : d8; endfunction

  // Reference: plain integer arithmetic on sign-extended / zero-extended operands.
  function automatic void model(int w, logic [3:0] g, longint unsigned av, longint unsigned bv,
                                longint unsigned sh, output longint unsigned s,
                                output longint unsigned h, output bit ov);
    longint unsigned m = (64'd1 << w) - 64'd1;
    longint smax = longint'((64'd1 << (w - 1)) - 64'd1);
    longint smin = -longint'(64'd1 << (w - 1));
    longint sa, sb, r;
    longint unsigned p;
    sa = ((av >> (w - 1)) & 64'd1) != 0 ? longint'(av) - longint'(64'd1 << w) : longint'(av);
    sb = ((bv >> (w - 1)) & 64'd1) != 0 ? longint'(bv) - longint'(64'd1 << w) : longint'(bv);
    s = 0; h = 0; ov = 0;
    case (g)
      4'd0:  s = av & bv;
      4'd1:  s = av | bv;
      4'd2:  begin r = sa + sb; s = longint'(r) & m; ov = (r > smax) || (r < smin); end
      4'd3:  s = bv >> sh;
      4'd4:  s = (bv << sh) & m;
      4'd5:  begin r = sb >>> sh; s = r & m; end
      4'd6:  begin r = sa - sb; s = longint'(r) & m; ov = (r > smax) || (r < smin); end
      4'd7:  s = (sa < sb) ? 1 : 0;
      4'd8:  s = av ^ bv;
      4'd9:  s = ~(av | bv) & m;
      4'd10: s = (av < bv) ? 1 : 0;
      4'd12: begin p = av * bv; s = p & m; h = p >> w; end
      4'd13: begin
        if (bv == 0) begin s = m; h = av; end
        else begin s = av / bv; h = av % bv; end
      end
      default: begin s = 0; h = 0; end
    endcase
  endfunction

  task automatic run_op(int w, logic [3:0] g, longint unsigned av, longint unsigned bv,
                        longint unsigned sh, bit inject, string tag);
    longint unsigned es, eh, m;
    bit eov, iter;
    int cyc;
    m = (64'd1 << w) - 64'd1;
    av &= m; bv &= m; sh &= longint'(w - 1);
    model(w, g, av, bv, sh, es, eh, eov);
    iter = (g == 4'hC) || (g == 4'hD);
    @(negedge clk);
    drive(w, 1'b1, g, av, bv, sh);
    @(posedge clk); #1;
    drive(w, 1'b0, 4'($urandom), $urandom, $urandom, $urandom);
    if (iter) begin
      check({tag, ".busy_on"}, obusy(w), 1);
      cyc = 0;
      while (odone(w) !== 1'b1 && cyc < 200) begin
        if (inject && cyc == 3) drive(w, 1'b1, 4'($urandom), $urandom, $urandom, $urandom);
        else                    drive(w, 1'b0, 4'($urandom), $urandom, $urandom, $urandom);
        @(posedge clk); #1;
        cyc++;
      end
      drive(w, 1'b0, 4'h0, 0, 0, 0);
      check({tag, ".latency"}, cyc, w);
      check({tag, ".busy_off"}, obusy(w), 0);
    end
    check({tag, ".done"}, odone(w), 1);
    check({tag, ".sum"}, osum(w), es);
    check({tag, ".hi"}, ohi(w), eh);
    check({tag, ".zout"}, ozout(w), (es == 0));
    check({tag, ".ovf"}, oovf(w), eov);
  endtask

  initial begin
    int dn;
    logic [3:0] g;
    reset = 1'b1;
    drive(32, 1'b0, 4'h0, 0, 0, 0);
    drive(8, 1'b0, 4'h0, 0, 0, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    check("rst.sum", osum(32), 0);
    check("rst.hi", ohi(32), 0);
    check("rst.zout", z32, 1);
    check("rst.ovf", o32, 0);
    check("rst.busy", bz32, 0);
    check("rst.done", d32, 0);
    check("rst8.busy", bz8, 0);

    run_op(32, 4'h2, 64'h7FFF_FFFF, 1, 0, 0, "add_ovf");
    run_op(32, 4'h6, 5, 5, 0, 0, "sub_zero");
    run_op(32, 4'h7, 64'h8000_0000, 1, 0, 0, "slt");
    run_op(32, 4'hA, 64'h8000_0000, 1, 0, 0, "sltu");
    run_op(32, 4'h5, 0, 64'hF000_0000, 4, 0, "sra");
    @(posedge clk); #1;
    check("done_pulse", d32, 0);

    @(negedge clk);
    drive(32, 1'b1, 4'hC, 7, 9, 0);
    @(posedge clk); #1;
    drive(32, 1'b0, 4'h0, 0, 0, 0);
    repeat (4) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("midrst.sum", osum(32), 0);
    check("midrst.hi", ohi(32), 0);
    check("midrst.zout", z32, 1);
    check("midrst.busy", bz32, 0);
    check("midrst.done", d32, 0);
    dn = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (d32) dn++;
    end
    check("midrst.no_done", dn, 0);

    @(negedge clk);
    drive(32, 1'b1, 4'hC, 3, 4, 0);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    drive(32, 1'b0, 4'h0, 0, 0, 0);
    @(posedge clk); #1;
    check("rst_start.busy", bz32, 0);
    check("rst_start.done", d32, 0);

    run_op(32, 4'hC, 64'hFFFF_FFFF, 64'hFFFF_FFFF, 0, 1, "multu_max");
    run_op(32, 4'hD, 100, 7, 0, 1, "divu");
    run_op(32, 4'hD, 123, 0, 0, 0, "divu_b0");
    run_op(32, 4'hF, 3, 4, 0, 0, "undef_op");

    run_op(8, 4'hC, 64'hC8, 3, 0, 0, "mul8");
    run_op(8, 4'hD, 64'hC8, 64'h0B, 0, 0, "div8_b2b");
    run_op(8, 4'hD, 64'h5A, 0, 0, 0, "div8_b0");

    for (int i = 0; i < 30; i++) begin
      g = 4'($urandom_range(0, 15));
      run_op((i % 3 == 0) ? 8 : 32, g, $urandom, $urandom, $urandom, $urandom_range(0, 1) == 1,
             $sformatf("rand%0d_op%0h", i, g));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
